// File: rtl/uart_cmd_ctrl.sv
//------------------------------------------------------------------------------
// Module   : uart_cmd_ctrl
// Purpose  : Frames read/write commands from a UART RX FIFO into register bus
//            accesses and returns ACK/NAK (plus read data) through the TX FIFO.
//            Optional macro CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_cmd_ctrl #(
   parameter int                   DATA_BITS   = 8,
   parameter int                   TIMEOUT_CYC = 1000000,
   parameter logic [DATA_BITS-1:0] SYNC_BYTE   = 8'hA5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_empty,
   input  logic [DATA_BITS-1:0] rx_data,
   output logic                 read_uart,
   input  logic                 tx_full,
   output logic                 write_uart,
   output logic [DATA_BITS-1:0] write_data,
   output logic [DATA_BITS-1:0] reg_addr,
   output logic [DATA_BITS-1:0] reg_wdata,
   output logic                 reg_we,
   input  logic [DATA_BITS-1:0] reg_rdata,
   output logic                 busy,
   output logic                 frame_err
);

   localparam logic [DATA_BITS-1:0] c_CMD_W = DATA_BITS'(8'h57);
   localparam logic [DATA_BITS-1:0] c_CMD_R = DATA_BITS'(8'h52);
   localparam logic [DATA_BITS-1:0] c_ACK   = DATA_BITS'(8'h06);
   localparam logic [DATA_BITS-1:0] c_NAK   = DATA_BITS'(8'h15);
   localparam int                   c_TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   // Last count value before abort: the state reads IDLE on gap cycle TIMEOUT_CYC-1.
   localparam logic [c_TW-1:0]      c_TO_LAST = c_TW'(TIMEOUT_CYC - 2);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_GET_CMD   = 4'd1,
      ST_GET_ADDR  = 4'd2,
      ST_GET_DATA  = 4'd3,
      ST_EXEC      = 4'd4,
      ST_SEND_ACK  = 4'd5,
      ST_SEND_DATA = 4'd6,
      ST_SEND_NAK  = 4'd7
`ifdef CHECKSUM_EN
      , ST_GET_CSUM = 4'd8
`endif
   } state_t;

   state_t                r_state;
   logic                  r_is_write;
   logic [DATA_BITS-1:0]  r_rd_buf;
   logic [c_TW-1:0]       r_tcnt;
   logic                  r_to_err;
`ifdef CHECKSUM_EN
   logic [DATA_BITS-1:0]  r_csum;
`endif

   logic w_in_get;
   logic w_in_send;
   logic w_pop;

`ifdef CHECKSUM_EN
   assign w_in_get = (r_state == ST_GET_CMD) || (r_state == ST_GET_ADDR) ||
                     (r_state == ST_GET_DATA) || (r_state == ST_GET_CSUM);
`else
   assign w_in_get = (r_state == ST_GET_CMD) || (r_state == ST_GET_ADDR) ||
                     (r_state == ST_GET_DATA);
`endif
   assign w_in_send = (r_state == ST_SEND_ACK) || (r_state == ST_SEND_DATA) ||
                      (r_state == ST_SEND_NAK);

   // FWFT FIFOs: pop and push are same-cycle handshakes, so they stay combinational.
   assign w_pop      = !rst && ((r_state == ST_IDLE) || w_in_get) && !rx_empty;
   assign read_uart  = w_pop;
   assign write_uart = !rst && w_in_send && !tx_full;
   assign frame_err  = r_to_err || (write_uart && (r_state == ST_SEND_NAK));
   assign busy       = (r_state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_is_write <= 1'b0;
         r_rd_buf   <= '0;
         r_tcnt     <= '0;
         r_to_err   <= 1'b0;
         write_data <= '0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_we     <= 1'b0;
`ifdef CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         reg_we   <= 1'b0;
         r_to_err <= 1'b0;

         if (w_in_get) begin
            if (!rx_empty) begin
               r_tcnt <= '0;
            end else if (r_tcnt == c_TO_LAST) begin
               r_tcnt   <= '0;
               r_to_err <= 1'b1;
               r_state  <= ST_IDLE;
            end else begin
               r_tcnt <= r_tcnt + 1'b1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (w_pop && (rx_data == SYNC_BYTE)) begin
                  r_state <= ST_GET_CMD;
                  r_tcnt  <= '0;
`ifdef CHECKSUM_EN
                  r_csum  <= '0;
`endif
               end
            end
            ST_GET_CMD: begin
               if (w_pop) begin
                  if ((rx_data == c_CMD_W) || (rx_data == c_CMD_R)) begin
                     r_is_write <= (rx_data == c_CMD_W);
                     r_state    <= ST_GET_ADDR;
`ifdef CHECKSUM_EN
                     r_csum     <= rx_data;
`endif
                  end else begin
                     write_data <= c_NAK;
                     r_state    <= ST_SEND_NAK;
                  end
               end
            end
            ST_GET_ADDR: begin
               if (w_pop) begin
                  reg_addr <= rx_data;
`ifdef CHECKSUM_EN
                  r_csum   <= r_csum ^ rx_data;
                  r_state  <= r_is_write ? ST_GET_DATA : ST_GET_CSUM;
`else
                  r_state  <= r_is_write ? ST_GET_DATA : ST_EXEC;
`endif
               end
            end
            ST_GET_DATA: begin
               if (w_pop) begin
                  reg_wdata <= rx_data;
`ifdef CHECKSUM_EN
                  r_csum    <= r_csum ^ rx_data;
                  r_state   <= ST_GET_CSUM;
`else
                  reg_we    <= 1'b1;
                  r_state   <= ST_EXEC;
`endif
               end
            end
`ifdef CHECKSUM_EN
            ST_GET_CSUM: begin
               if (w_pop) begin
                  if (rx_data == r_csum) begin
                     reg_we  <= r_is_write;
                     r_state <= ST_EXEC;
                  end else begin
                     write_data <= c_NAK;
                     r_state    <= ST_SEND_NAK;
                  end
               end
            end
`endif
            ST_EXEC: begin
               r_rd_buf   <= reg_rdata;
               write_data <= c_ACK;
               r_state    <= ST_SEND_ACK;
            end
            ST_SEND_ACK: begin
               if (!tx_full) begin
                  if (r_is_write) begin
                     r_state <= ST_IDLE;
                  end else begin
                     write_data <= r_rd_buf;
                     r_state    <= ST_SEND_DATA;
                  end
               end
            end
            ST_SEND_DATA: begin
               if (!tx_full) r_state <= ST_IDLE;
            end
            ST_SEND_NAK: begin
               if (!tx_full) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
